// File: rtl/input_mapper.sv
// Player-input mapper: PS/2 key events are looked up in a downloadable key map
// and merged with joystick bits into per-player button vectors; coin lanes are stretched.
module input_mapper #(
    parameter int PLAYERS     = 2,
    parameter int BUTTONS     = 8,
    parameter int MAP_DEPTH   = 32,
    parameter int COIN_BIT    = 7,
    parameter int COIN_CYCLES = 2400000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [10:0]                      ps2_key,
    input  logic [PLAYERS*BUTTONS-1:0]       joy,
    input  logic [$clog2(2*MAP_DEPTH)-1:0]   map_addr,
    input  logic [7:0]                       map_data,
    input  logic                             map_wr,
    output logic [PLAYERS*BUTTONS-1:0]       buttons,
    output logic                             busy
);

    localparam int NB = PLAYERS * BUTTONS;
    localparam int AW = $clog2(2 * MAP_DEPTH);
    localparam int IW = $clog2(MAP_DEPTH);
    localparam int CW = $clog2(COIN_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Key map RAM; attribute bytes power up zero so every entry is invalid.
    // Writes have no reset term because reset is held during download.
    // ------------------------------------------------------------------
    logic [7:0]    code_mem [MAP_DEPTH];
    logic [7:0]    attr_mem [MAP_DEPTH] = '{default: 8'h00};
    logic [IW-1:0] map_entry;
    logic          map_in_range;
    logic [7:0]    rd_code_reg;
    logic [7:0]    rd_attr_reg;

    assign map_entry    = map_addr[AW-1:1];
    assign map_in_range = 32'(map_addr) < 32'(2 * MAP_DEPTH);

    always_ff @(posedge clk) begin
        if (map_wr && map_in_range) begin
            if (map_addr[0]) begin
                attr_mem[map_entry] <= map_data;
            end else begin
                code_mem[map_entry] <= map_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event detect and scan FSM
    // ------------------------------------------------------------------
    logic          toggle_reg;
    logic          evt;
    state_t        state_reg, state_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [9:0]    cur_evt_reg, cur_evt_next;
    logic [9:0]    pend_evt_reg, pend_evt_next;
    logic          pend_full_reg, pend_full_next;
    logic          idx_last;

    assign evt      = ps2_key[10] ^ toggle_reg;
    assign idx_last = (idx_reg == IW'(MAP_DEPTH - 1));
    assign busy     = (state_reg != ST_IDLE);

    always_ff @(posedge clk) begin
        toggle_reg <= ps2_key[10];
        if (reset) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            cur_evt_reg   <= '0;
            pend_evt_reg  <= '0;
            pend_full_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            cur_evt_reg   <= cur_evt_next;
            pend_evt_reg  <= pend_evt_next;
            pend_full_reg <= pend_full_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        cur_evt_next   = cur_evt_reg;
        pend_evt_next  = pend_evt_reg;
        pend_full_next = pend_full_reg;
        case (state_reg)
            ST_IDLE: begin
                if (evt) begin
                    cur_evt_next = ps2_key[9:0];
                    idx_next     = '0;
                    state_next   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (evt && !pend_full_reg) begin
                    pend_evt_next  = ps2_key[9:0];
                    pend_full_next = 1'b1;
                end
                if (idx_last) begin
                    state_next = ST_DONE;
                end else begin
                    idx_next = idx_reg + IW'(1);
                end
            end
            ST_DONE: begin
                idx_next = '0;
                if (pend_full_reg) begin
                    // The held event runs next; a coincident new one takes its slot.
                    cur_evt_next   = pend_evt_reg;
                    pend_full_next = evt;
                    if (evt) begin
                        pend_evt_next = ps2_key[9:0];
                    end
                    state_next = ST_SCAN;
                end else if (evt) begin
                    cur_evt_next = ps2_key[9:0];
                    state_next   = ST_SCAN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Compare stage: RAM data arrives one cycle after its index, so the
    // event and last-entry flag travel alongside it.
    // ------------------------------------------------------------------
    logic       s1_valid_reg;
    logic       s1_last_reg;
    logic [9:0] s1_evt_reg;

    always_ff @(posedge clk) begin
        rd_code_reg <= code_mem[idx_reg];
        rd_attr_reg <= attr_mem[idx_reg];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_evt_reg   <= '0;
        end else begin
            s1_valid_reg <= (state_reg == ST_SCAN);
            s1_last_reg  <= (state_reg == ST_SCAN) && idx_last;
            s1_evt_reg   <= cur_evt_reg;
        end
    end

    logic [1:0]    hit_player;
    logic [3:0]    hit_button;
    logic          hit;
    logic [NB-1:0] work_reg, work_next;
    logic [NB-1:0] key_reg;

    assign hit_player = rd_attr_reg[5:4];
    assign hit_button = rd_attr_reg[3:0];
    assign hit = s1_valid_reg && rd_attr_reg[7]
              && (rd_code_reg == s1_evt_reg[7:0])
              && (rd_attr_reg[6] == s1_evt_reg[8])
              && (32'(hit_player) < 32'(PLAYERS))
              && (32'(hit_button) < 32'(BUTTONS));

    always_comb begin
        work_next = work_reg;
        for (int p = 0; p < PLAYERS; p++) begin
            for (int b = 0; b < BUTTONS; b++) begin
                if (hit && hit_player == 2'(p) && hit_button == 4'(b)) begin
                    work_next[p*BUTTONS + b] = s1_evt_reg[9];
                end
            end
        end
    end

    // Matches accumulate in work_reg and become visible only when a scan completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            work_reg <= '0;
            key_reg  <= '0;
        end else begin
            work_reg <= work_next;
            if (s1_last_reg) begin
                key_reg <= work_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output merge and per-player coin stretcher
    // ------------------------------------------------------------------
    logic [NB-1:0] buttons_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            buttons_reg <= joy;
        end else begin
            buttons_reg <= key_reg | joy;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < PLAYERS; gi++) begin : g_player
            if (COIN_BIT < BUTTONS) begin : g_coin
                localparam logic [BUTTONS-1:0] COIN_MASK = BUTTONS'(1) << COIN_BIT;
                logic          src;
                logic          src_prev_reg;
                logic          coin_on_reg;
                logic [CW-1:0] cnt_reg;

                assign src = key_reg[gi*BUTTONS + COIN_BIT] | joy[gi*BUTTONS + COIN_BIT];

                always_ff @(posedge clk) begin
                    if (reset) begin
                        src_prev_reg <= joy[gi*BUTTONS + COIN_BIT];
                        coin_on_reg  <= 1'b0;
                        cnt_reg      <= '0;
                    end else begin
                        src_prev_reg <= src;
                        if (!coin_on_reg && src && !src_prev_reg) begin
                            coin_on_reg <= 1'b1;
                            cnt_reg     <= CW'(COIN_CYCLES - 1);
                        end else if (coin_on_reg) begin
                            if (cnt_reg == '0) begin
                                coin_on_reg <= 1'b0;
                            end else begin
                                cnt_reg <= cnt_reg - CW'(1);
                            end
                        end
                    end
                end

                assign buttons[gi*BUTTONS +: BUTTONS] =
                    (buttons_reg[gi*BUTTONS +: BUTTONS] & ~COIN_MASK)
                    | (coin_on_reg ? COIN_MASK : '0);
            end else begin : g_plain
                assign buttons[gi*BUTTONS +: BUTTONS] = buttons_reg[gi*BUTTONS +: BUTTONS];
            end
        end
    endgenerate

endmodule

// File: tb/tb_input_mapper.sv
// Directed bench for input_mapper: key-map lookup, scan timing, pending slot,
// coin stretching and reset-during-scan.
module tb_input_mapper;

    localparam int PLAYERS     = 2;
    localparam int BUTTONS     = 8;
    localparam int MAP_DEPTH   = 4;
    localparam int COIN_BIT    = 7;
    localparam int COIN_CYCLES = 8;

    logic        clk;
    logic        reset;
    logic [10:0] ps2_key;
    logic [15:0] joy;
    logic [2:0]  map_addr;
    logic [7:0]  map_data;
    logic        map_wr;
    logic [15:0] buttons;
    logic        busy;

    int checks = 0;
    int errors = 0;

    input_mapper #(
        .PLAYERS    (PLAYERS),
        .BUTTONS    (BUTTONS),
        .MAP_DEPTH  (MAP_DEPTH),
        .COIN_BIT   (COIN_BIT),
        .COIN_CYCLES(COIN_CYCLES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ps2_key (ps2_key),
        .joy     (joy),
        .map_addr(map_addr),
        .map_data(map_data),
        .map_wr  (map_wr),
        .buttons (buttons),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic map_write(input logic [2:0] addr, input logic [7:0] data);
        map_addr = addr;
        map_data = data;
        map_wr   = 1'b1;
        tick(1);
        map_wr   = 1'b0;
        $display("map write addr=%0d data=%02h", addr, data);
    endtask

    task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pressed, ext, code};
        $display("key event pressed=%0b ext=%0b code=%02h", pressed, ext, code);
    endtask

    initial begin
        int high;
        int high_p1;

        reset    = 1'b1;
        ps2_key  = '0;
        joy      = 16'h0201;
        map_addr = '0;
        map_data = '0;
        map_wr   = 1'b0;
        tick(3);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_buttons_joy", 32'(buttons), 32'h0201);
        reset = 1'b0;
        joy   = 16'h0000;
        tick(1);
        check("post_reset_buttons", 32'(buttons), 32'h0000);
        check("post_reset_busy", 32'(busy), 32'd0);

        // Entry 0: 0x6B -> player 0 button 1; measure latency.
        map_write(3'd0, 8'h6B);
        map_write(3'd1, 8'h81);
        send_key(1'b1, 1'b0, 8'h6B);
        check("pre_event_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("scan_busy", 32'(busy), 32'd1);
            check("scan_buttons_low", 32'(buttons), 32'h0000);
        end
        tick(1);
        check("scan_end_busy", 32'(busy), 32'd0);
        check("buttons_before_latency", 32'(buttons), 32'h0000);
        tick(1);
        check("press_latency6", 32'(buttons), 32'h0002);
        $display("press 0x6B -> buttons=%04h", buttons);
        send_key(1'b0, 1'b0, 8'h6B);
        tick(7);
        check("release_6b", 32'(buttons), 32'h0000);

        // Entry 1: extended 0x75 -> player 0 button 3.
        map_write(3'd2, 8'h75);
        map_write(3'd3, 8'hC3);
        send_key(1'b1, 1'b0, 8'h75);
        tick(7);
        check("ext_mismatch", 32'(buttons), 32'h0000);
        send_key(1'b1, 1'b1, 8'h75);
        tick(7);
        check("ext_match", 32'(buttons), 32'h0008);

        // Entries 2,3: 0x14 -> button 4 of both players.
        map_write(3'd4, 8'h14);
        map_write(3'd5, 8'h84);
        map_write(3'd6, 8'h14);
        map_write(3'd7, 8'h94);
        send_key(1'b1, 1'b0, 8'h14);
        tick(7);
        check("multi_match", 32'(buttons), 32'h1018);

        // Three toggles back to back: press, release queued, third dropped.
        send_key(1'b1, 1'b0, 8'h6B);
        tick(1);
        check("b2b_busy_e0", 32'(busy), 32'd1);
        send_key(1'b0, 1'b0, 8'h6B);
        tick(1);
        check("b2b_busy_e1", 32'(busy), 32'd1);
        send_key(1'b1, 1'b0, 8'h6B);
        tick(1);
        check("b2b_busy_e2", 32'(busy), 32'd1);
        for (int i = 3; i < 10; i++) begin
            tick(1);
            check("b2b_busy", 32'(busy), 32'd1);
            if (i == 6) check("b2b_first_applied", 32'(buttons), 32'h101A);
        end
        tick(1);
        check("b2b_busy_end", 32'(busy), 32'd0);
        tick(1);
        check("b2b_second_applied", 32'(buttons), 32'h1018);
        tick(6);
        check("b2b_third_dropped_busy", 32'(busy), 32'd0);
        check("b2b_third_dropped_buttons", 32'(buttons), 32'h1018);

        // Coin: held source gives one 8-cycle pulse.
        joy  = 16'h0080;
        high = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (i == 0) check("coin_first_cycle", 32'(buttons), 32'h1098);
            if (buttons[7]) high++;
        end
        check("coin_hold_width", 32'(high), 32'd8);
        $display("coin hold -> pulse width %0d", high);
        joy = 16'h0000;
        tick(2);
        joy     = 16'h8080;
        high    = 0;
        high_p1 = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (buttons[7]) high++;
            if (buttons[15]) high_p1++;
        end
        check("coin_retrigger_p0", 32'(high), 32'd8);
        check("coin_retrigger_p1", 32'(high_p1), 32'd8);
        joy = 16'h0000;
        tick(2);
        joy  = 16'h0080;
        high = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (buttons[7]) high++;
        end
        joy = 16'h0000;
        tick(1);
        if (buttons[7]) high++;
        joy = 16'h0080;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (buttons[7]) high++;
        end
        check("coin_no_extend", 32'(high), 32'd8);
        joy = 16'h0000;
        tick(1);

        // Reset in mid-scan while a map byte is written.
        send_key(1'b1, 1'b0, 8'h6B);
        tick(3);
        check("midscan_busy", 32'(busy), 32'd1);
        reset    = 1'b1;
        map_addr = 3'd0;
        map_data = 8'h1C;
        map_wr   = 1'b1;
        tick(1);
        reset  = 1'b0;
        map_wr = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_buttons", 32'(buttons), 32'h0000);
        tick(7);
        check("abort_no_partial", 32'(buttons), 32'h0000);
        check("abort_idle", 32'(busy), 32'd0);
        send_key(1'b1, 1'b0, 8'h1C);
        tick(7);
        check("written_in_reset", 32'(buttons), 32'h0002);
        send_key(1'b1, 1'b0, 8'h6B);
        tick(7);
        check("old_code_gone", 32'(buttons), 32'h0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_mapper.md
Name: input_mapper

Overview:
- Generalised player-input block replacing hard-coded per-game PS/2 key decoding.
- Decodes PS/2 key events through a runtime-loadable key map (ioctl download) into per-player button vectors and ORs in joystick bits.
- Stretches coin inputs to a fixed pulse width for the game core.
- Sits between hps_io and the game module, in the clk_sys domain.

Parameters:
- PLAYERS, 2: number of players, 1..4.
- BUTTONS, 8: bits per player vector, 1..16.
- MAP_DEPTH, 32: key-map entries, power of two, 2..64.
- COIN_BIT, 7: button index treated as coin.
- COIN_CYCLES, 2400000: coin pulse length in clk cycles (50 ms at 48 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ps2_key  in  11  hps_io key event: [10] toggle, [9] pressed, [8] extended, [7:0] scancode.
- joy  in  PLAYERS*BUTTONS  joystick bits, player p at [p*BUTTONS +: BUTTONS].
- map_addr  in  $clog2(2*MAP_DEPTH)  ioctl byte address.
- map_data  in  8  ioctl byte.
- map_wr  in  1  write strobe (already qualified by ioctl index).
- buttons  out  PLAYERS*BUTTONS  merged key|joy state; COIN_BIT lanes carry the stretched coin.
- busy  out  1  scan in progress.

Behaviour:
- Map RAM: entry e occupies bytes 2e and 2e+1.
  - Byte0: scancode.
  - Byte1: {valid[7], ext[6], player[5:4], button[3:0]}.
- Map writes are accepted regardless of reset, because reset is held during download.
- Map RAM is not cleared by reset and powers up all-invalid.
- Map writes to addresses at or above 2*MAP_DEPTH are ignored.
- Event detect: a registered copy of ps2_key[10] is compared against the current value. A difference is an event, and {pressed, ext, code} is latched.
- FSM states:
  - IDLE: on event, go to SCAN with idx=0 and busy=1.
  - SCAN: read entry idx, one entry per cycle. On match, set key bit [player*BUTTONS+button] to pressed. Match requires: valid, code equal, ext equal, player<PLAYERS, button<BUTTONS. After idx=MAP_DEPTH-1, go to DONE.
  - DONE: if the pending slot is full, load it, clear it, and go to SCAN with idx=0. Otherwise go to IDLE with busy=0.
- Latency: key bit updates MAP_DEPTH+1 cycles after the event edge is sampled. buttons reflect the update on the next cycle.
- Multiple matching entries all apply; one key may drive several buttons or players.
- Pending slot is 1-deep.
  - An event during SCAN or DONE fills it.
  - An event while it is full is dropped.
  - Simultaneous event and DONE: the held pending event is loaded and the new event fills the slot.
- Out-of-range player or button entries are ignored.
- Coin, per player:
  - Source is the merged key|joy bit at COIN_BIT.
  - A rising edge, while the counter is idle, loads the counter with COIN_CYCLES-1 and drives the coin lane high.
  - The lane stays high for exactly COIN_CYCLES cycles, regardless of source level.
  - Edges during the pulse are ignored.
  - Retrigger requires a new rising edge after the pulse ends.
  - If COIN_BIT>=BUTTONS, no stretching is applied.
- Reset behaviour:
  - FSM goes to IDLE, pending cleared, busy=0.
  - Key state cleared.
  - Coin counters cleared.
  - Edge registers loaded from current inputs, so no spurious event or coin after reset.
  - Reset mid-scan aborts the scan with no partial effects retained.
- Reset values: buttons = joy-derived only (coin lanes 0 until an edge), busy=0.

Test Plan:
Unless stated otherwise, the bench uses PLAYERS=2, BUTTONS=8, MAP_DEPTH=4, COIN_BIT=7, COIN_CYCLES=8.
1. Load entry0 = {0x6B, 0x81} (valid, p0, b1). Toggle ps2_key with pressed=1, code 0x6B -> buttons[1]=1 exactly 6 cycles after the toggle, busy high 5 cycles. Release event -> buttons[1]=0.
2. Load entry1 = {0x75, 0xC3} (ext, p0, b3). Send code 0x75 with ext=0 -> no change. Send with ext=1 -> buttons[3]=1.
3. Load entries2,3 with code 0x14 for p0 b4 and p1 b4. One press event -> buttons[4]=1 and buttons[12]=1.
4. Send three toggles on consecutive cycles -> first and second processed back-to-back (busy continuous, 10 cycles), third dropped.
5. Hold joy[7] high for 20 cycles -> buttons[7] high exactly 8 cycles. Then release and reassert -> second 8-cycle pulse. Reassert during a pulse -> no extension.
6. Assert reset mid-scan with map_wr active -> key state 0, busy=0, map byte written and usable after reset.
